// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Instruction-side responder for the core's fetch interface. A byte-serial
// valid/ready load port fills a word memory at boot (bytes assembled
// little-endian), the core is held in reset until loading completes, and the
// core's word-index `pointer` is then answered combinationally on `instr_out`.
//
// Ports:
//   clk            system clock
//   _reset         synchronous, active-high reset
//   pointer        instruction word index from the core (not a byte address)
//   instr_out      instruction word for `pointer` (0 while loading / out of range)
//   core_hold      drive into the core's reset; high while loading
//   load_start     pulse: restart loading from word 0 (highest priority)
//   load_valid     load byte present
//   load_byte      load data byte
//   load_ready     loader accepts a byte this cycle
//   load_done      pulse: host finished; pads and commits a partial word
//   words_loaded   words written since the last load start
//   load_checksum  (INSTR_MEM_CHECKSUM_EN only) sum of word[15:0]+word[31:16]
//                  over committed words, mod 2^16
//
// Optional feature macro: INSTR_MEM_CHECKSUM_EN
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic [31:0]       pointer,
    output logic [31:0]       instr_out,
    output logic              core_hold,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    input  logic              load_done,
    output logic [ADDR_W:0]   words_loaded
`ifdef INSTR_MEM_CHECKSUM_EN
    ,
    output logic [15:0]       load_checksum
`endif
);

    localparam int              DEPTH = 1 << ADDR_W;
    // Write address one past the last word: the memory is full.
    localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Lanes 0..2 of the word being assembled; lane 3 arrives with the commit.
    // Cleared after every commit so a padded final word has zero upper lanes.
    logic [23:0]       asm_q, asm_d;

    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem [DEPTH];

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        core_hold  = 1'b1;
        load_ready = 1'b0;

        case (state_q)
            ST_LOAD: begin
                core_hold  = 1'b1;
                load_ready = (wr_addr_q != FULL);
            end
            ST_RUN: begin
                core_hold  = 1'b0;
                load_ready = 1'b0;
            end
            default: begin
                core_hold  = 1'b1;
                load_ready = 1'b0;
            end
        endcase

        if (load_start) begin
            // Restart wins over load_done and drops any byte offered this cycle.
            state_d    = ST_LOAD;
            wr_addr_d  = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
        end else if (state_q == ST_LOAD) begin
            if (load_valid && load_ready) begin
                case (byte_cnt_q)
                    2'd0: asm_d[7:0]   = load_byte;
                    2'd1: asm_d[15:8]  = load_byte;
                    2'd2: asm_d[23:16] = load_byte;
                    default: begin
                        mem_we    = 1'b1;
                        mem_wdata = {load_byte, asm_q};
                        asm_d     = '0;
                    end
                endcase
                byte_cnt_d = byte_cnt_q + 2'd1;
            end

            if (load_done) begin
                // A byte accepted this cycle is already folded into asm_d;
                // a non-zero lane count means a partial word is pending.
                // That byte cannot have been lane 3, so no commit is in flight.
                if (byte_cnt_d != 2'd0) begin
                    mem_we     = 1'b1;
                    mem_wdata  = {8'h00, asm_d};
                    byte_cnt_d = '0;
                    asm_d      = '0;
                end
                state_d = ST_RUN;
            end

            if (mem_we) begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (_reset) begin
            state_q    <= ST_LOAD;
            wr_addr_q  <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // ------------------------------------------------------------------
    // Word memory: single synchronous write port, combinational read
    // ------------------------------------------------------------------
    // NOTE: the memory array has no reset; contents survive a reset and are
    // simply overwritten by the next load.
    always_ff @(posedge clk) begin
        if (mem_we && !_reset) begin
            mem[wr_addr_q[ADDR_W-1:0]] <= mem_wdata;
        end
    end

    always_comb begin
        instr_out = '0;
        if (state_q == ST_RUN && pointer[31:ADDR_W] == '0) begin
            instr_out = mem[pointer[ADDR_W-1:0]];
        end
    end

    // Every committed word advances the write address by one, so the count
    // since the last load start is the write address itself.
    assign words_loaded = wr_addr_q;

`ifdef INSTR_MEM_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (_reset || load_start) begin
            csum_q <= '0;
        end else if (mem_we) begin
            csum_q <= csum_q + mem_wdata[15:0] + mem_wdata[31:16];
        end
    end

    assign load_checksum = csum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//
// Drives two loaders from the same stimulus: u_a with the default 256-word
// memory and u_b with ADDR_W = 2 (4 words) so the full condition is reached.
// A byte/word-level model of both is compared against every output on each
// falling edge, and a set of hand-computed literals pins the model.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        _reset;
    logic [31:0] pointer;
    logic        load_start, load_valid, load_done;
    logic [7:0]  load_byte;

    logic [31:0] instr_a, instr_b;
    logic        hold_a, hold_b, ready_a, ready_b;
    logic [8:0]  words_a;
    logic [2:0]  words_b;
`ifdef INSTR_MEM_CHECKSUM_EN
    logic [15:0] csum_a, csum_b;
`endif

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_W(8)) u_a (
        .clk(clk), ._reset(_reset), .pointer(pointer), .instr_out(instr_a),
        .core_hold(hold_a), .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(ready_a), .load_done(load_done),
        .words_loaded(words_a)
`ifdef INSTR_MEM_CHECKSUM_EN
        , .load_checksum(csum_a)
`endif
    );

    instr_mem_loader #(.ADDR_W(2)) u_b (
        .clk(clk), ._reset(_reset), .pointer(pointer), .instr_out(instr_b),
        .core_hold(hold_b), .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(ready_b), .load_done(load_done),
        .words_loaded(words_b)
`ifdef INSTR_MEM_CHECKSUM_EN
        , .load_checksum(csum_b)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bytes since load start, grouped into words
    // ------------------------------------------------------------------
    int          dep [2] = '{256, 4};
    bit          live = 1'b0;
    bit          m_run   [2];
    int          m_words [2];
    int          m_pcnt  [2];
    logic [7:0]  m_pb    [2][4];
    logic [31:0] m_mem   [2][256];
    bit          m_known [2][256];
    logic [15:0] m_csum  [2];

    function automatic bit m_ready(input int k);
        return !m_run[k] && (m_words[k] < dep[k]);
    endfunction

    task automatic m_commit(input int k);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < m_pcnt[k]; i++) w[8*i +: 8] = m_pb[k][i];
        m_mem[k][m_words[k]]   = w;
        m_known[k][m_words[k]] = 1'b1;
        m_csum[k]  = m_csum[k] + w[15:0] + w[31:16];
        m_words[k] = m_words[k] + 1;
        m_pcnt[k]  = 0;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (_reset === 1'b1 || load_start === 1'b1) begin
                m_run[k]   = 1'b0;
                m_words[k] = 0;
                m_pcnt[k]  = 0;
                m_csum[k]  = '0;
            end else if (live && !m_run[k]) begin
                if (load_valid && m_ready(k)) begin
                    m_pb[k][m_pcnt[k]] = load_byte;
                    m_pcnt[k] = m_pcnt[k] + 1;
                    if (m_pcnt[k] == 4) m_commit(k);
                end
                if (load_done) begin
                    if (m_pcnt[k] != 0) m_commit(k);
                    m_run[k] = 1'b1;
                end
            end
        end
        if (_reset === 1'b1) live = 1'b1;
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] o_instr, o_words, e_instr;
                logic        o_hold, o_ready;
                bit          known;
                o_instr = (k == 0) ? instr_a : instr_b;
                o_hold  = (k == 0) ? hold_a  : hold_b;
                o_ready = (k == 0) ? ready_a : ready_b;
                o_words = (k == 0) ? 32'(words_a) : 32'(words_b);
                check($sformatf("u%0d.core_hold", k), 32'(o_hold), 32'(!m_run[k]));
                check($sformatf("u%0d.load_ready", k), 32'(o_ready), 32'(m_ready(k)));
                check($sformatf("u%0d.words_loaded", k), o_words, 32'(m_words[k]));
                known   = 1'b1;
                e_instr = '0;
                if (m_run[k] && pointer < 32'(dep[k])) begin
                    known   = m_known[k][pointer[7:0]];
                    e_instr = m_mem[k][pointer[7:0]];
                end
                if (known) check($sformatf("u%0d.instr_out[%0d]", k, pointer), o_instr, e_instr);
`ifdef INSTR_MEM_CHECKSUM_EN
                check($sformatf("u%0d.load_checksum", k),
                      32'((k == 0) ? csum_a : csum_b), 32'(m_csum[k]));
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input logic done);
        load_valid = 1'b1;
        load_byte  = b;
        load_done  = done;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic look(input logic [31:0] p);
        pointer = p;
        @(negedge clk);
    endtask

    initial begin
        _reset     = 1'b1;
        pointer    = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_done  = 1'b0;
        load_byte  = '0;
        tick();
        tick();
        _reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset.core_hold", 32'(hold_a), 32'd1);
        check("reset.load_ready", 32'(ready_a), 32'd1);
        check("reset.words_loaded", 32'(words_a), 32'd0);
        check("reset.instr_out", instr_a, 32'h0);

        // One full word, then load_done
        put(8'h78, 1'b0); put(8'h56, 1'b0); put(8'h34, 1'b0); put(8'h12, 1'b0);
        @(negedge clk);
        check("w1.hold_before_done", 32'(hold_a), 32'd1);
        pulse_done();
        look(32'd0);
        check("w1.core_hold", 32'(hold_a), 32'd0);
        check("w1.words_loaded", 32'(words_a), 32'd1);
        check("w1.instr_out", instr_a, 32'h12345678);

        // Six bytes, load_done with the sixth: padded second word
        pulse_start();
        for (int i = 1; i <= 6; i++) put(8'(i), (i == 6));
        look(32'd0);
        check("pad.word0", instr_a, 32'h04030201);
        look(32'd1);
        check("pad.word1", instr_a, 32'h00000605);
        check("pad.words_loaded", 32'(words_a), 32'd2);

        // Stream 20 bytes with valid held high: u_b fills after 16
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'(8'h10 + i);
            tick();
            if (i == 14) begin
                @(negedge clk);
                check("full.ready_before", 32'(ready_b), 32'd1);
            end
            if (i == 15) begin
                @(negedge clk);
                check("full.ready_after16", 32'(ready_b), 32'd0);
            end
        end
        load_valid = 1'b0;
        pulse_done();
        look(32'd4);
        check("full.b_words", 32'(words_b), 32'd4);
        check("full.b_ptr4", instr_b, 32'h0);
        check("full.a_words", 32'(words_a), 32'd5);
        check("full.a_ptr4", instr_a, 32'h23222120);
        look(32'd3);
        check("full.b_ptr3", instr_b, 32'h1F1E1D1C);

        // load_start in RUN with a byte offered: byte dropped, hold rises
        load_valid = 1'b1;
        load_byte  = 8'h99;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        look(32'd0);
        check("restart.core_hold", 32'(hold_a), 32'd1);
        check("restart.instr_out", instr_a, 32'h0);
        check("restart.words", 32'(words_a), 32'd0);
        put(8'hDD, 1'b0); put(8'hCC, 1'b0); put(8'hBB, 1'b0); put(8'hAA, 1'b0);
        pulse_done();
        look(32'd0);
        check("restart.reload", instr_a, 32'hAABBCCDD);

        // load_done in RUN is ignored; start+done together restarts
        pulse_done();
        load_start = 1'b1;
        load_done  = 1'b1;
        tick();
        load_start = 1'b0;
        load_done  = 1'b0;
        @(negedge clk);
        check("both.core_hold", 32'(hold_a), 32'd1);

        // Host stalls randomly, with a reset mid-load
        for (int i = 0; i < 60; i++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_byte  = 8'($urandom);
            pointer    = 32'($urandom_range(0, 7));
            if (i == 25) _reset = 1'b1;
            tick();
            _reset = 1'b0;
        end
        load_valid = 1'b0;
        put(8'h5A, 1'b1);
        for (int p = 0; p < 12; p++) look(32'(p));
        look(32'h0000_0100);
        look(32'hFFFF_FFFF);
        check("oob.instr_out", instr_a, 32'h0);

`ifdef INSTR_MEM_CHECKSUM_EN
        pulse_start();
        put(8'h02, 1'b0); put(8'h00, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b0);
        put(8'h01, 1'b0); put(8'h00, 1'b0); put(8'hFF, 1'b0); put(8'hFF, 1'b0);
        pulse_done();
        @(negedge clk);
        check("csum.value", 32'(csum_a), 32'h0003);
        pulse_start();
        @(negedge clk);
        check("csum.cleared", 32'(csum_a), 32'h0000);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
